arbutterfly_puf_ctrl: RTL

Challenge sequencer for the Arbiter-Butterfly PUF core behind the AXI4-Lite register block. On a start pulse it expands a 32-bit seed challenge through an LFSR into RESP_BITS challenges. Each challenge is evaluated NVOTE times with an excite/settle/sample/relax cycle, and a majority vote forms each response bit. It sits between the AXI slave registers (start, challenge, settle, response, status) and the PUF core.

---
 rtl/arbutterfly_puf_pkg.sv | 25 ++
 rtl/arbutterfly_majority_voter.sv | 29 ++
 rtl/arbutterfly_puf_ctrl.sv | 142 ++++++++++++++
 3 files changed

// File: rtl/arbutterfly_puf_pkg.sv
// Shared types and the challenge-expansion LFSR for the Arbiter-Butterfly PUF sequencer.
package arbutterfly_puf_pkg;

  localparam int CHAL_W = 32;

  // Feedback taps for x^32+x^22+x^2+x+1, taken as bits 31, 21, 1 and 0 of the current state
  localparam logic [CHAL_W-1:0] LFSR_TAPS = 32'h8020_0003;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SETUP,
    ST_EXCITE,
    ST_SAMPLE,
    ST_RELAX,
    ST_VOTE,
    ST_DONE
  } state_t;

  // Fibonacci step: shift left and append the XOR of the tapped bits.
  // An all-zero state maps to itself.
  function automatic logic [CHAL_W-1:0] lfsr_next(input logic [CHAL_W-1:0] c);
    return {c[CHAL_W-2:0], ^(c & LFSR_TAPS)};
  endfunction

endpackage

// File: rtl/arbutterfly_majority_voter.sv
// Counts ones across the NVOTE evaluations of a single challenge.
// It also reports the majority decision and whether all votes agreed.
module arbutterfly_majority_voter #(
  parameter int  NVOTE = 7,
  localparam int CW    = $clog2(NVOTE + 1)
) (
  input  logic clock,
  input  logic reset,
  input  logic clr,
  input  logic acc,
  input  logic bit_in,
  output logic decision,
  output logic unanimous
);

  logic [CW-1:0] ones;

  // Ones accumulator: cleared between bits, bumped once per sampled evaluation
  always_ff @(posedge clock) begin
    if (reset || clr)
      ones <= '0;
    else if (acc && bit_in)
      ones <= ones + CW'(1);
  end

  assign decision  = (ones > CW'(NVOTE / 2));
  assign unanimous = (ones == '0) || (ones == CW'(NVOTE));

endmodule

// File: rtl/arbutterfly_puf_ctrl.sv
// Challenge sequencer: expands a seed through the LFSR, evaluates each challenge
// NVOTE times (excite/settle/sample/relax) and majority-votes each response bit.
module arbutterfly_puf_ctrl
  import arbutterfly_puf_pkg::*;
#(
  parameter int RESP_BITS = 32,
  parameter int NVOTE     = 7,   // odd, >= 1
  localparam int UW       = $clog2(RESP_BITS + 1)
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic                 start,
  input  logic                 abort,
  input  logic [CHAL_W-1:0]    challenge_in,
  input  logic [7:0]           settle_cycles,
  output logic [CHAL_W-1:0]    puf_chal,
  output logic                 puf_excite,
  input  logic                 puf_resp,
  output logic                 busy,
  output logic                 done,
  output logic [RESP_BITS-1:0] response,
  output logic [UW-1:0]        unstable_cnt
);

  localparam int BW = (RESP_BITS > 1) ? $clog2(RESP_BITS) : 1;
  localparam int VW = $clog2(NVOTE + 1);

  state_t            state;
  logic [CHAL_W-1:0] chal_reg;
  logic [7:0]        s_reg;
  logic [7:0]        cnt;
  logic [BW-1:0]     bit_idx;
  logic [VW-1:0]     vote_idx;
  logic              start_ok;
  logic              vote_dec;
  logic              vote_unan;

  assign puf_chal = chal_reg;
  assign start_ok = start && ((state == ST_IDLE) || (state == ST_DONE));

  arbutterfly_majority_voter #(.NVOTE(NVOTE)) u_voter (
    .clock     (clock),
    .reset     (reset),
    .clr       (start_ok || (state == ST_VOTE)),
    .acc       (state == ST_SAMPLE),
    .bit_in    (puf_resp),
    .decision  (vote_dec),
    .unanimous (vote_unan)
  );

  // Sequencer FSM; busy/puf_excite/done are registered alongside the state transition
  always_ff @(posedge clock) begin
    if (reset) begin
      state        <= ST_IDLE;
      chal_reg     <= '0;
      s_reg        <= '0;
      cnt          <= '0;
      bit_idx      <= '0;
      vote_idx     <= '0;
      response     <= '0;
      unstable_cnt <= '0;
      puf_excite   <= 1'b0;
      busy         <= 1'b0;
      done         <= 1'b0;
    end else if (busy && abort) begin
      // Partial response and unstable_cnt are left visible on purpose
      state      <= ST_IDLE;
      puf_excite <= 1'b0;
      busy       <= 1'b0;
      done       <= 1'b0;
    end else begin
      case (state)
        ST_IDLE, ST_DONE: begin
          if (start) begin
            done <= 1'b0;
            if (abort) begin
              state <= ST_IDLE;
            end else begin
              state        <= ST_SETUP;
              busy         <= 1'b1;
              chal_reg     <= challenge_in;
              s_reg        <= (settle_cycles == 8'd0) ? 8'd1 : settle_cycles;
              bit_idx      <= '0;
              vote_idx     <= '0;
              response     <= '0;
              unstable_cnt <= '0;
            end
          end
        end
        ST_SETUP: begin
          state      <= ST_EXCITE;
          cnt        <= s_reg - 8'd1;
          puf_excite <= 1'b1;
        end
        ST_EXCITE: begin
          if (cnt == 8'd0)
            state <= ST_SAMPLE;
          else
            cnt <= cnt - 8'd1;
        end
        ST_SAMPLE: begin
          state      <= ST_RELAX;
          vote_idx   <= vote_idx + VW'(1);
          cnt        <= s_reg - 8'd1;
          puf_excite <= 1'b0;
        end
        ST_RELAX: begin
          if (cnt != 8'd0) begin
            cnt <= cnt - 8'd1;
          end else if (vote_idx < VW'(NVOTE)) begin
            state      <= ST_EXCITE;
            cnt        <= s_reg - 8'd1;
            puf_excite <= 1'b1;
          end else begin
            state <= ST_VOTE;
          end
        end
        ST_VOTE: begin
          response[bit_idx] <= vote_dec;
          if (!vote_unan)
            unstable_cnt <= unstable_cnt + UW'(1);
          chal_reg <= lfsr_next(chal_reg);
          vote_idx <= '0;
          if (bit_idx == BW'(RESP_BITS - 1)) begin
            state <= ST_DONE;
            busy  <= 1'b0;
            done  <= 1'b1;
          end else begin
            bit_idx <= bit_idx + BW'(1);
            state   <= ST_SETUP;
          end
        end
        default: begin
          state      <= ST_IDLE;
          busy       <= 1'b0;
          puf_excite <= 1'b0;
        end
      endcase
    end
  end

endmodule
